// File: rtl/troy_pkg.sv
// Shared types for the data-memory arbiter: requester IDs, FSM states and dmem geometry.
package troy_pkg;

  localparam int unsigned DMEM_AW      = 8;
  localparam int unsigned DMEM_DW      = 128;
  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_BOOST  = 1'b1
  } state_e;

  // Owner tag carried alongside an outstanding memory read
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delays the owner tag of each granted read by the memory read latency so the
// returning data can be steered to the requester that issued it.
module rd_tag_pipe
  import troy_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [LAT-1:0] pipe_q;
  rd_tag_t [LAT-1:0] pipe_d;

  if (LAT > 1) begin : g_shift
    assign pipe_d = {pipe_q[LAT-2:0], tag_i};
  end else begin : g_single
    assign pipe_d = tag_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_o = pipe_q[LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the CPU (priority) and the debug/DMA
// port, with a starvation guard for debug, and steers read data back to its owner.
module dmem_arbiter
  import troy_pkg::*;
#(
  parameter int unsigned AW         = DMEM_AW,
  parameter int unsigned DW         = DMEM_DW,
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e                  state_q, state_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [DW-1:0]           cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]           dbg_rdata_q, dbg_rdata_d;
  logic                    dbg_wins;
  rd_tag_t                 push_tag, tail_tag;

  // Grant selection, starvation counter and NORMAL/BOOST transitions
  always_comb begin
    state_d      = ST_NORMAL;
    starve_cnt_d = '0;
    dbg_wins     = 1'b0;
    cpu_gnt      = 1'b0;
    dbg_gnt      = 1'b0;

    case (state_q)
      ST_BOOST: dbg_wins = dbg_req;
      default:  dbg_wins = dbg_req & ~cpu_req;
    endcase

    if (reset) begin
      dbg_gnt = dbg_wins;
      cpu_gnt = cpu_req & ~dbg_wins;
    end

    if ((state_q == ST_NORMAL) && dbg_req && !dbg_gnt) begin
      if (starve_cnt_q != '1) begin
        starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
      if (starve_cnt_d >= STARVE_CNT_W'(STARVE_MAX)) begin
        state_d = ST_BOOST;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_NORMAL;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Memory port mux; with no grant the CPU request fields are presented
  always_comb begin
    mem_en    = cpu_gnt | dbg_gnt;
    mem_wr_en = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (dbg_gnt) begin
      mem_wr_en = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_wr_en = cpu_we;
    end
    if (!reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_comb begin
    push_tag.valid = mem_en & ~mem_wr_en;
    push_tag.id    = dbg_gnt ? REQ_DBG : REQ_CPU;
  end

  rd_tag_pipe #(
    .LAT (MEM_RD_LAT)
  ) u_rd_tag_pipe (
    .clk_i  (clk),
    .rst_ni (reset),
    .tag_i  (push_tag),
    .tag_o  (tail_tag)
  );

  // Tail of the tag pipe: pulse rvalid and pass mem_rdata straight through
  always_comb begin
    cpu_rvalid  = tail_tag.valid && (tail_tag.id == REQ_CPU);
    dbg_rvalid  = tail_tag.valid && (tail_tag.id == REQ_DBG);
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    if (cpu_rvalid) begin
      cpu_rdata_d = mem_rdata;
    end
    if (dbg_rvalid) begin
      dbg_rdata_d = mem_rdata;
    end
    cpu_rdata = cpu_rdata_d;
    dbg_rdata = dbg_rdata_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed traffic against a behavioural dmem, checked
// every cycle by a request-level model plus hand-computed expectations.
module tb_dmem_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  logic         clk, reset;
  logic         cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0]   cpu_addr, dbg_addr;
  logic [127:0] cpu_wdata, dbg_wdata;
  logic         cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [127:0] cpu_rdata, dbg_rdata;
  logic         mem_en, mem_wr_en;
  logic [7:0]   mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  logic         cpu_req3;
  logic [7:0]   cpu_addr3;
  logic         cpu_gnt3, cpu_rvalid3, dbg_gnt3, dbg_rvalid3;
  logic [127:0] cpu_rdata3, dbg_rdata3;
  logic         mem_en3, mem_wr_en3;
  logic [7:0]   mem_addr3;
  logic [127:0] mem_wdata3, mem_rdata3, rd3_a, rd3_b;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.AW(8), .DW(128), .MEM_RD_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.AW(8), .DW(128), .MEM_RD_LAT(3), .STARVE_MAX(STARVE_MAX)) u_dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req3), .cpu_we(1'b0), .cpu_addr(cpu_addr3), .cpu_wdata(128'h0),
    .cpu_gnt(cpu_gnt3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(8'h00), .dbg_wdata(128'h0),
    .dbg_gnt(dbg_gnt3), .dbg_rvalid(dbg_rvalid3), .dbg_rdata(dbg_rdata3),
    .mem_en(mem_en3), .mem_wr_en(mem_wr_en3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dmems: write-first, read latency 1 and 3
  logic [127:0] mem  [256];
  logic [127:0] mem3 [256];
  logic [127:0] smem [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) mem[mem_addr] <= mem_wdata;
      else           mem_rdata     <= mem[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (mem_en3) begin
      if (mem_wr_en3) mem3[mem_addr3] <= mem_wdata3;
      else            rd3_a           <= mem3[mem_addr3];
    end
    rd3_b      <= rd3_a;
    mem_rdata3 <= rd3_b;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request-level model: CPU wins unless debug has lost STARVE_MAX cycles in a row;
  // reads return LAT=1 cycle after their grant with the memory contents at that time.
  typedef struct {
    int           cyc;
    logic         id;
    logic [127:0] d;
  } ret_t;

  ret_t         rq[$];
  int           cyc = 0;
  int           lost = 0;
  logic [127:0] exp_crd = '0;
  logic [127:0] exp_drd = '0;

  always @(negedge clk) begin : model
    logic       e_dg, e_cg, e_crv, e_drv, e_we;
    logic [7:0] e_addr;
    ret_t       r;
    cyc = cyc + 1;
    if (!reset) begin
      rq.delete();
      lost    = 0;
      exp_crd = '0;
      exp_drd = '0;
      chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
      chk1("rst_dbg_gnt", dbg_gnt, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_wr_en", mem_wr_en, 1'b0);
      chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk1("rst_dbg_rvalid", dbg_rvalid, 1'b0);
      chkw("rst_cpu_rdata", cpu_rdata, 128'h0);
      chkw("rst_dbg_rdata", dbg_rdata, 128'h0);
    end else begin
      e_dg  = dbg_req && (!cpu_req || lost >= int'(STARVE_MAX));
      e_cg  = cpu_req && !e_dg;
      e_crv = 1'b0;
      e_drv = 1'b0;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        if (r.id) begin e_drv = 1'b1; exp_drd = r.d; end
        else      begin e_crv = 1'b1; exp_crd = r.d; end
      end
      e_addr = e_dg ? dbg_addr : cpu_addr;
      e_we   = e_dg ? dbg_we : (e_cg & cpu_we);
      chk1("m_cpu_gnt", cpu_gnt, e_cg);
      chk1("m_dbg_gnt", dbg_gnt, e_dg);
      chk1("m_mem_en", mem_en, e_dg | e_cg);
      chk1("m_mem_wr_en", mem_wr_en, e_we);
      chkw("m_mem_addr", 128'(mem_addr), 128'(e_addr));
      chkw("m_mem_wdata", mem_wdata, e_dg ? dbg_wdata : cpu_wdata);
      chk1("m_cpu_rvalid", cpu_rvalid, e_crv);
      chk1("m_dbg_rvalid", dbg_rvalid, e_drv);
      chkw("m_cpu_rdata", cpu_rdata, exp_crd);
      chkw("m_dbg_rdata", dbg_rdata, exp_drd);
      if (e_dg || e_cg) begin
        if (e_we) smem[e_addr] = e_dg ? dbg_wdata : cpu_wdata;
        else      rq.push_back('{cyc: cyc + 1, id: e_dg, d: smem[e_addr]});
      end
      lost = (!dbg_req || e_dg) ? 0 : lost + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [9:0]   pat10;
    logic [4:0]   pat5;
    logic [6:0]   rv3;
    logic [127:0] magic;
    magic = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = {16{8'(i)}};
      mem3[i] = {16{8'(i)}};
      smem[i] = {16{8'(i)}};
    end
    mem_rdata = '0; mem_rdata3 = '0; rd3_a = '0; rd3_b = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    cpu_req3 = 1'b0; cpu_addr3 = '0;
    reset = 1'b1;
    #1 reset = 1'b0;

    // No grant while reset is held, even with a request present
    step(); cpu_req = 1'b1;
    #1 chk1("rst_no_grant", cpu_gnt, 1'b0);
    step(); cpu_req = 1'b0; reset = 1'b1;
    step();

    // 1: CPU read of 0x05
    step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    #1 chk1("t1_gnt", cpu_gnt, 1'b1);
    step(); cpu_req = 1'b0;
    #1 chk1("t1_rvalid", cpu_rvalid, 1'b1);
    chkw("t1_rdata", cpu_rdata, {16{8'h05}});
    chk1("t1_dbg_rvalid", dbg_rvalid, 1'b0);

    // 2: both requesting continuously -> 4:1 CPU:debug
    step(); cpu_req = 1'b1; cpu_addr = 8'h07; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h09;
    for (int k = 0; k < 10; k++) begin
      #1 pat10[k] = dbg_gnt;
      step();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chkw("t2_dbg_pattern", 128'(pat10), 128'(10'b10_0001_0000));

    // 3: debug write then CPU read of the same word
    step(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h10; dbg_wdata = magic;
    #1 chk1("t3_dbg_gnt", dbg_gnt, 1'b1);
    chk1("t3_wr_en", mem_wr_en, 1'b1);
    step(); dbg_req = 1'b0; dbg_we = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    #1 chk1("t3_cpu_gnt", cpu_gnt, 1'b1);
    chk1("t3_rd_wr_en", mem_wr_en, 1'b0);
    step(); cpu_req = 1'b0;
    #1 chk1("t3_rvalid", cpu_rvalid, 1'b1);
    chkw("t3_rdata", cpu_rdata, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);

    // 4: interleaved reads CPU@1, DBG@2, CPU@3
    step(); cpu_req = 1'b1; cpu_addr = 8'h01;
    step(); cpu_req = 1'b0; dbg_req = 1'b1; dbg_addr = 8'h02;
    #1 chk1("t4_cpu_rv1", cpu_rvalid, 1'b1);
    chkw("t4_cpu_rd1", cpu_rdata, {16{8'h01}});
    chk1("t4_dbg_gnt", dbg_gnt, 1'b1);
    step(); dbg_req = 1'b0; cpu_req = 1'b1; cpu_addr = 8'h03;
    #1 chk1("t4_dbg_rv", dbg_rvalid, 1'b1);
    chkw("t4_dbg_rd", dbg_rdata, {16{8'h02}});
    chk1("t4_cpu_rv_off", cpu_rvalid, 1'b0);
    step(); cpu_req = 1'b0;
    #1 chk1("t4_cpu_rv3", cpu_rvalid, 1'b1);
    chkw("t4_cpu_rd3", cpu_rdata, {16{8'h03}});
    chkw("t4_dbg_hold", dbg_rdata, {16{8'h02}});

    // 5: build up starvation, reset with a read in flight, then confirm a fresh count
    step(); cpu_req = 1'b1; cpu_addr = 8'h04; dbg_req = 1'b1; dbg_addr = 8'h06;
    step();
    step(); reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    #1 chk1("t5_rvalid", cpu_rvalid, 1'b0);
    chk1("t5_mem_en", mem_en, 1'b0);
    chkw("t5_cpu_rdata", cpu_rdata, 128'h0);
    chkw("t5_dbg_rdata", dbg_rdata, 128'h0);
    step(); step(); reset = 1'b1;
    step(); step();
    step(); cpu_req = 1'b1; dbg_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 pat5[k] = dbg_gnt;
      step();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chkw("t5_starve_cleared", 128'(pat5), 128'(5'b10000));

    // 6: latency-3 instance, three back-to-back CPU reads
    step();
    for (int k = 0; k < 7; k++) begin
      cpu_req3  = (k < 3);
      cpu_addr3 = 8'(8'h11 + k);
      #1 rv3[k] = cpu_rvalid3;
      if (k < 3) chk1("t6_gnt", cpu_gnt3, 1'b1);
      if (k >= 3 && k <= 5) chkw("t6_rdata", cpu_rdata3, {16{8'(8'h11 + k - 3)}});
      step();
    end
    cpu_req3 = 1'b0;
    chkw("t6_rvalid_pattern", 128'(rv3), 128'(7'b0111000));

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
